// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter
//
// Serialises block transfers from an instruction cache and a data cache
// onto a single main-memory port. One transfer is in flight at a time;
// the other initiator is held on its BUSY_WAIT until the arbiter is free.
//
// Optional feature (compile-time macro): ARB_ROUND_ROBIN_EN
//   undefined : the data side always wins a same-cycle collision.
//   defined   : a collision goes to the side that did not win the previous
//               collision (data side wins the first one after reset).
//
// Ports
//   CLK, RESET                    clock, asynchronous active-low reset
//   INS_MEM_READ/ADDRESS          instruction-cache block read request
//   INS_MEM_READ_DATA/BUSY_WAIT   returned block / stall to instruction cache
//   DATA_MEM_READ/WRITE/ADDRESS   data-cache request (read+write = write)
//   DATA_MEM_WRITE_DATA           block to be written
//   DATA_MEM_READ_DATA/BUSY_WAIT  returned block / stall to data cache
//   MEM_READ/WRITE/ADDRESS        strobes and address to main memory
//   MEM_WRITE_DATA/READ_DATA      block to / from main memory
//   MEM_BUSY_WAIT                 main-memory stall
module main_mem_arbiter (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         INS_MEM_READ,
    input  logic [27:0]  INS_MEM_ADDRESS,
    output logic [127:0] INS_MEM_READ_DATA,
    output logic         INS_MEM_BUSY_WAIT,
    input  logic         DATA_MEM_READ,
    input  logic         DATA_MEM_WRITE,
    input  logic [27:0]  DATA_MEM_ADDRESS,
    input  logic [127:0] DATA_MEM_WRITE_DATA,
    output logic [127:0] DATA_MEM_READ_DATA,
    output logic         DATA_MEM_BUSY_WAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITE_DATA,
    input  logic [127:0] MEM_READ_DATA,
    input  logic         MEM_BUSY_WAIT
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_e;

    state_e         state_q, state_d;
    logic [27:0]    addr_q, addr_d;
    logic [127:0]   wdata_q, wdata_d;
    logic           write_q, write_d;
    logic           first_q, first_d;
    logic           ins_done_q, ins_done_d;
    logic           data_done_q, data_done_d;
    logic [127:0]   ins_rdata_q, ins_rdata_d;
    logic [127:0]   data_rdata_q, data_rdata_d;

    logic           ins_req;
    logic           data_req;
    logic           pick_data;
    logic           in_grant;

    assign ins_req  = INS_MEM_READ;
    assign data_req = DATA_MEM_READ | DATA_MEM_WRITE;

`ifdef ARB_ROUND_ROBIN_EN
    // Winner of the last contested grant; only collisions update it so that
    // uncontested traffic does not disturb the alternation.
    logic last_data_q, last_data_d;

    assign pick_data = data_req & (~ins_req | ~last_data_q);

    always_comb begin
        last_data_d = last_data_q;
        if (state_q == IDLE && ins_req && data_req) begin
            last_data_d = pick_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    assign pick_data = data_req;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        first_d      = 1'b0;
        ins_done_d   = 1'b0;
        data_done_d  = 1'b0;
        ins_rdata_d  = ins_rdata_q;
        data_rdata_d = data_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_data) begin
                    state_d = GRANT_D;
                    addr_d  = DATA_MEM_ADDRESS;
                    wdata_d = DATA_MEM_WRITE_DATA;
                    write_d = DATA_MEM_WRITE;
                    first_d = 1'b1;
                end else if (ins_req) begin
                    state_d = GRANT_I;
                    addr_d  = INS_MEM_ADDRESS;
                    write_d = 1'b0;
                    first_d = 1'b1;
                end
            end
            GRANT_I: begin
                // Memory stall is not yet meaningful on the first grant cycle.
                if (!first_q && !MEM_BUSY_WAIT) begin
                    state_d    = DONE;
                    ins_done_d = 1'b1;
                    // A requester that has walked away gets nothing written back.
                    if (ins_req) begin
                        ins_rdata_d = MEM_READ_DATA;
                    end
                end
            end
            GRANT_D: begin
                if (!first_q && !MEM_BUSY_WAIT) begin
                    state_d     = DONE;
                    data_done_d = 1'b1;
                    if (!write_q && data_req) begin
                        data_rdata_d = MEM_READ_DATA;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            first_q      <= 1'b0;
            ins_done_q   <= 1'b0;
            data_done_q  <= 1'b0;
            ins_rdata_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            first_q      <= first_d;
            ins_done_q   <= ins_done_d;
            data_done_q  <= data_done_d;
            ins_rdata_q  <= ins_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

    // write_q is only ever set for a data grant, so the strobes are exclusive.
    assign MEM_READ       = in_grant & ~write_q;
    assign MEM_WRITE      = in_grant & write_q;
    assign MEM_ADDRESS    = addr_q;
    assign MEM_WRITE_DATA = wdata_q;

    assign INS_MEM_READ_DATA  = ins_rdata_q;
    assign DATA_MEM_READ_DATA = data_rdata_q;
    assign INS_MEM_BUSY_WAIT  = ins_req & ~ins_done_q;
    assign DATA_MEM_BUSY_WAIT = data_req & ~data_done_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a small latency-programmable
// main-memory model. Read data is derived from the address so each port's
// returned block is distinguishable.
module tb_main_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_rd = 1'b0;
    logic [27:0]  i_addr = '0;
    logic [127:0] i_rdata;
    logic         i_busy;
    logic         d_rd = 1'b0;
    logic         d_wr = 1'b0;
    logic [27:0]  d_addr = '0;
    logic [127:0] d_wdata = '0;
    logic [127:0] d_rdata;
    logic         d_busy;
    logic         mem_rd;
    logic         mem_wr;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_busy;

    int n_cmp = 0;
    int n_err = 0;
    int mem_lat = 0;
    int mem_cnt = 0;
    int overlap_n = 0;

    localparam logic [127:0] PatA5 = {16{8'hA5}};
    localparam logic [127:0] WrDat = {4{32'h1234_5678}};

    always #5 clk = ~clk;

    main_mem_arbiter dut (
        .CLK                 (clk),
        .RESET               (rst_n),
        .INS_MEM_READ        (i_rd),
        .INS_MEM_ADDRESS     (i_addr),
        .INS_MEM_READ_DATA   (i_rdata),
        .INS_MEM_BUSY_WAIT   (i_busy),
        .DATA_MEM_READ       (d_rd),
        .DATA_MEM_WRITE      (d_wr),
        .DATA_MEM_ADDRESS    (d_addr),
        .DATA_MEM_WRITE_DATA (d_wdata),
        .DATA_MEM_READ_DATA  (d_rdata),
        .DATA_MEM_BUSY_WAIT  (d_busy),
        .MEM_READ            (mem_rd),
        .MEM_WRITE           (mem_wr),
        .MEM_ADDRESS         (mem_addr),
        .MEM_WRITE_DATA      (mem_wdata),
        .MEM_READ_DATA       (mem_rdata),
        .MEM_BUSY_WAIT       (mem_busy)
    );

    // Memory model: stalls for mem_lat cycles counted from the first strobe cycle.
    always @(posedge clk) mem_cnt <= (mem_rd || mem_wr) ? mem_cnt + 1 : 0;
    assign mem_busy  = (mem_rd || mem_wr) && (mem_cnt < mem_lat);
    assign mem_rdata = (mem_addr == 28'h4) ? PatA5 : {4{4'h0, mem_addr}};

    always @(negedge clk) if (mem_rd && mem_wr) overlap_n++;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit dside, input bit rd, input bit wr, input logic [27:0] addr,
                        input logic [127:0] wd, input int lat, output int busy_cyc,
                        output int rd_cyc, output int wr_cyc, output logic [27:0] seen_addr,
                        output logic [127:0] seen_wdata, output logic [127:0] got_rdata);
        mem_lat = lat;
        @(posedge clk); #1;
        if (dside) begin
            d_rd = rd; d_wr = wr; d_addr = addr; d_wdata = wd;
        end else begin
            i_rd = rd; i_addr = addr;
        end
        busy_cyc = 0; rd_cyc = 0; wr_cyc = 0; seen_addr = '0; seen_wdata = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_rd) begin
                rd_cyc++;
                seen_addr = mem_addr;
            end
            if (mem_wr) begin
                wr_cyc++;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
            end
            if (dside ? d_busy : i_busy) busy_cyc++;
            else break;
        end
        got_rdata = dside ? d_rdata : i_rdata;
        @(posedge clk); #1;
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    // Both caches issue reads in the same cycle; reports which address reached
    // memory first and the cycle index at which each side's stall dropped.
    task automatic collide(input logic [27:0] ia, input logic [27:0] da,
                           output logic [27:0] first_addr, output int i_rel, output int d_rel,
                           output logic [127:0] i_got, output logic [127:0] d_got);
        bit seen;
        mem_lat = 0;
        seen = 1'b0; first_addr = '0; i_rel = -1; d_rel = -1; i_got = '0; d_got = '0;
        @(posedge clk); #1;
        i_rd = 1'b1; i_addr = ia; d_rd = 1'b1; d_addr = da;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!seen && mem_rd) begin
                seen = 1'b1;
                first_addr = mem_addr;
            end
            if (d_rel < 0 && !d_busy) begin d_rel = c; d_got = d_rdata; end
            if (i_rel < 0 && !i_busy) begin i_rel = c; i_got = i_rdata; end
            @(posedge clk); #1;
            if (d_rel >= 0) d_rd = 1'b0;
            if (i_rel >= 0) i_rd = 1'b0;
            if (d_rel >= 0 && i_rel >= 0) break;
        end
        i_rd = 1'b0; d_rd = 1'b0;
    endtask

    initial begin
        int bc, rc, wc, ir, dr;
        logic [27:0]  sa, fa;
        logic [127:0] sw, gr, ig, dg;

        // Reset state
        #3;
        check_eq("rst_mem_read", 128'(mem_rd), 128'(0));
        check_eq("rst_mem_write", 128'(mem_wr), 128'(0));
        check_eq("rst_mem_addr", 128'(mem_addr), 128'(0));
        check_eq("rst_mem_wdata", mem_wdata, 128'(0));
        check_eq("rst_i_rdata", i_rdata, 128'(0));
        check_eq("rst_d_rdata", d_rdata, 128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // I-read, memory stalls two cycles
        xfer(1'b0, 1'b1, 1'b0, 28'h4, '0, 2, bc, rc, wc, sa, sw, gr);
        check_eq("iread_busy_cycles", 128'(bc), 128'(4));
        check_eq("iread_strobe_cycles", 128'(rc), 128'(3));
        check_eq("iread_no_write", 128'(wc), 128'(0));
        check_eq("iread_addr", 128'(sa), 128'(28'h4));
        check_eq("iread_data", gr, PatA5);

        // D-read, minimum latency
        xfer(1'b1, 1'b1, 1'b0, 28'h20, '0, 0, bc, rc, wc, sa, sw, gr);
        check_eq("dread_busy_cycles", 128'(bc), 128'(3));
        check_eq("dread_strobe_cycles", 128'(rc), 128'(2));
        check_eq("dread_data", gr, {4{32'h0000_0020}});

        // D-write, memory stalls three cycles; read data must not move
        xfer(1'b1, 1'b0, 1'b1, 28'h10, WrDat, 3, bc, rc, wc, sa, sw, gr);
        check_eq("dwrite_busy_cycles", 128'(bc), 128'(5));
        check_eq("dwrite_strobe_cycles", 128'(wc), 128'(4));
        check_eq("dwrite_no_read", 128'(rc), 128'(0));
        check_eq("dwrite_addr", 128'(sa), 128'(28'h10));
        check_eq("dwrite_data", sw, WrDat);
        check_eq("dwrite_rdata_kept", gr, {4{32'h0000_0020}});

        // Read and write both high behaves as a write
        xfer(1'b1, 1'b1, 1'b1, 28'h30, ~WrDat, 0, bc, rc, wc, sa, sw, gr);
        check_eq("rdwr_write_cycles", 128'(wc), 128'(2));
        check_eq("rdwr_no_read", 128'(rc), 128'(0));
        check_eq("rdwr_wdata", sw, ~WrDat);
        check_eq("rdwr_rdata_kept", gr, {4{32'h0000_0020}});

        // First collision: data side wins in both builds
        collide(28'h40, 28'h50, fa, ir, dr, ig, dg);
        check_eq("col1_first_addr", 128'(fa), 128'(28'h50));
        check_eq("col1_d_release", 128'(dr), 128'(3));
        check_eq("col1_i_release", 128'(ir), 128'(7));
        check_eq("col1_d_data", dg, {4{32'h0000_0050}});
        check_eq("col1_i_data", ig, {4{32'h0000_0040}});

        // Second collision: winner depends on the arbitration build
        collide(28'h60, 28'h70, fa, ir, dr, ig, dg);
`ifdef ARB_ROUND_ROBIN_EN
        check_eq("col2_first_addr", 128'(fa), 128'(28'h60));
        check_eq("col2_i_release", 128'(ir), 128'(3));
        check_eq("col2_d_release", 128'(dr), 128'(7));
`else
        check_eq("col2_first_addr", 128'(fa), 128'(28'h70));
        check_eq("col2_d_release", 128'(dr), 128'(3));
        check_eq("col2_i_release", 128'(ir), 128'(7));
`endif
        check_eq("col2_d_data", dg, {4{32'h0000_0070}});
        check_eq("col2_i_data", ig, {4{32'h0000_0060}});

        // Reset in the middle of a data grant
        mem_lat = 5;
        @(posedge clk); #1;
        d_rd = 1'b1; d_addr = 28'h80;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstg_strobe_before", 128'(mem_rd), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstg_mem_read", 128'(mem_rd), 128'(0));
        check_eq("rstg_mem_write", 128'(mem_wr), 128'(0));
        check_eq("rstg_mem_addr", 128'(mem_addr), 128'(0));
        check_eq("rstg_d_rdata", d_rdata, 128'(0));
        check_eq("rstg_i_rdata", i_rdata, 128'(0));
        mem_lat = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        // Request still held: must be a fresh IDLE cycle, no stale completion
        check_eq("rstg_busy_after", 128'(d_busy), 128'(1));
        check_eq("rstg_idle_after", 128'(mem_rd), 128'(0));
        // Requester walks away mid-grant: transfer finishes, result discarded
        @(posedge clk); #1;
        d_rd = 1'b0;
        @(negedge clk);
        check_eq("drop_strobe_kept", 128'(mem_rd), 128'(1));
        @(negedge clk);
        @(negedge clk);
        check_eq("drop_strobe_done", 128'(mem_rd), 128'(0));
        check_eq("drop_rdata_discard", d_rdata, 128'(0));

        // Normal service resumes after reset
        xfer(1'b0, 1'b1, 1'b0, 28'h90, '0, 0, bc, rc, wc, sa, sw, gr);
        check_eq("post_busy_cycles", 128'(bc), 128'(3));
        check_eq("post_data", gr, {4{32'h0000_0090}});

        check_eq("strobe_overlap", 128'(overlap_n), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named CLK and RESET as elsewhere in the codebase.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RESET  input  1  asynchronous active-low reset.
REQ-004 INS_MEM_READ  input  1  instruction-cache block read request.
REQ-005 INS_MEM_ADDRESS  input  28  instruction block address.
REQ-006 INS_MEM_READ_DATA  output  128  block returned to instruction cache.
REQ-007 INS_MEM_BUSY_WAIT  output  1  stall to instruction cache.
REQ-008 DATA_MEM_READ, DATA_MEM_WRITE  input  1 each  data-cache block read/write request.
REQ-009 DATA_MEM_ADDRESS  input  28; DATA_MEM_WRITE_DATA  input  128.
REQ-010 DATA_MEM_READ_DATA  output  128; DATA_MEM_BUSY_WAIT  output  1.
REQ-011 MEM_READ, MEM_WRITE  output  1 each  strobes to the single backing main memory.
REQ-012 MEM_ADDRESS  output  28; MEM_WRITE_DATA  output  128; MEM_READ_DATA  input  128; MEM_BUSY_WAIT  input  1.

Function
REQ-013 The block SHALL act as responder to two cache initiators and as initiator to one main memory, serialising all block transfers.
REQ-014 FSM states SHALL be IDLE, GRANT_I, GRANT_D, DONE.
REQ-015 In IDLE, with pending request(s), the FSM SHALL move at the next edge to the grant state of the winner and latch address, write data and operation type.
REQ-016 Default arbitration: data side wins when both request in the same cycle.
REQ-017 In a GRANT state, MEM_READ or MEM_WRITE SHALL be high with the latched address/data; MEM_BUSY_WAIT SHALL be ignored on the first GRANT cycle.
REQ-018 From the second GRANT cycle, MEM_BUSY_WAIT low at a rising edge SHALL capture MEM_READ_DATA (reads only) into the granted port's read-data register and move to DONE.
REQ-019 In DONE, both memory strobes SHALL be low; the granted port's done flag SHALL be high for exactly one cycle; next state is IDLE.
REQ-020 x_BUSY_WAIT SHALL equal (x request asserted) AND NOT (x done flag), combinationally, so busy rises in the same cycle as the request.
REQ-021 Minimum request-to-release latency SHALL be 3 cycles of BUSY_WAIT high (grant entry, one memory-wait cycle, DONE transition), plus one cycle per extra memory busy cycle.
REQ-022 x_READ_DATA SHALL hold its last captured value until the next read completion on that port; writes SHALL not modify it.
REQ-023 DATA_MEM_READ and DATA_MEM_WRITE both high SHALL be treated as a write.
REQ-024 An initiator dropping its request mid-grant SHALL not abort the memory transaction; it completes and the result is discarded.
REQ-025 The losing port SHALL stay busy and be granted from the IDLE cycle after DONE, with no request lost.
REQ-026 MEM_READ and MEM_WRITE SHALL never be high simultaneously.

Reset
REQ-027 RESET low SHALL immediately force IDLE, clear done flags, drive MEM_READ, MEM_WRITE low and MEM_ADDRESS, MEM_WRITE_DATA, both read-data outputs to 0.
REQ-028 Reset during GRANT SHALL abandon the memory transaction; no completion is reported after reset release.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the port not granted last (last-grant register reset to instruction side, so data wins first); without it, fixed data-side priority per REQ-016.

Verification
REQ-030 I-read 0x0000004, memory busy 2 cycles, returns 0xA5..A5 -> INS_MEM_BUSY_WAIT high 4 cycles, INS_MEM_READ_DATA=0xA5..A5, MEM_READ pulse 3 cycles.
REQ-031 D-write 0x0000010 data 0x1234..5678 -> MEM_WRITE high with exact address/data, DATA_MEM_READ_DATA unchanged.
REQ-032 I-read and D-read same cycle -> data served first, instruction served next; INS busy held throughout; without macro repeat -> data first again; with ARB_ROUND_ROBIN_EN, second collision -> instruction first.
REQ-033 RESET low during GRANT_D -> strobes low same cycle, outputs 0; after release no DONE pulse, FSM in IDLE.
REQ-034 DATA_MEM_READ and DATA_MEM_WRITE both high -> only MEM_WRITE asserted; MEM_READ and MEM_WRITE never high together throughout run.
